fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined datapath.
- Replaces the fixed 2-bit fad/fbd selects and the externally driven flush with values generated in the unit.
- Keeps an internal scoreboard of in-flight destination registers over NSTAGES post-decode stages.
- Produces per-operand forward selects, load-use stalls, a multi-cycle branch flush, and saturating stall/flush event counters.

Parameters:
- REG_AW, 5, register-index width.
- NSTAGES, 3, tracked stages after decode (index 0 = EX … NSTAGES-1 = WB); legal range 2 to 6.
- LOAD_LAT, 1, lowest stage index whose load result is forwardable; legal range 0 to NSTAGES-1.
- FLUSH_CYCLES, 1, cycles flush stays high per taken branch; legal range 1 to 4.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- idValid  in  1  decode stage holds a real instruction.
- idRs  in  REG_AW  decode source A index.
- idRt  in  REG_AW  decode source B index.
- idDst  in  REG_AW  decode destination, already muxed by regDst.
- idRegWrite  in  1  decode instruction writes the register file.
- idIsLoad  in  1  decode instruction is a load (mem2Reg).
- branchTaken  in  1  resolved taken branch this cycle (pcSrc).
- fad  out  FW=$clog2(NSTAGES+1)  operand A select: 0 = register file, k = stage k-1 result.
- fbd  out  FW  operand B select, same encoding as fad.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- flush  out  1  squash IF/ID.
- stallCnt  out  CNT_W  stall cycles seen, saturating.
- flushCnt  out  CNT_W  flush cycles seen, saturating.

Behaviour:
- Scoreboard entry i has fields {v, we, ld, dst}.
- Reset, asynchronous and immediate:
  - All entries cleared to zero.
  - Flush down-counter = 0.
  - stallCnt = 0, flushCnt = 0.
  - Hence fad = 0, fbd = 0, stall = 0, flush = 0.
- Every rising edge, entry i <= entry i-1 for i ≥ 1. The WB entry falls off.
- Entry 0 loads the decode instruction {idValid, idRegWrite, idIsLoad, idDst} only when stall = 0 and flush = 0. Otherwise entry 0 loads a bubble (all zero).
- Match for source s in stage i: v & we & (dst == s) & (s != 0).
- Select for s:
  - Find the smallest i that matches.
  - If none matches, the select is 0.
  - If the entry at that i has ld = 1 and i < LOAD_LAT, the select is 0 and the entry raises a load-use hazard.
  - Otherwise the select is i+1.
  - Older matches are never used in place of the youngest.
- A load-use hazard on operand A applies only if idValid. On operand B it applies only if idValid and the instruction is not an immediate-B instruction; the datapath masks idRt to 0 for immediate-B instructions.
- stall = hazardA | hazardB, and is 0 whenever flush = 1.
- Flush:
  - flush = branchTaken | (flushDown != 0).
  - On branchTaken, flushDown <= FLUSH_CYCLES-1, and fad/fbd/stall are still computed normally.
  - Otherwise flushDown decrements toward 0 without wrapping.
  - A branchTaken during an active flush reloads the counter.
- fad, fbd, stall and flush are combinational from the scoreboard, the decode inputs and flushDown. Latency is 0 cycles; registered state updates on the edge.
- stallCnt increments on each edge where stall = 1; flushCnt increments on each edge where flush = 1. Both hold at all-ones.
- Stall persists until the load reaches stage LOAD_LAT: LOAD_LAT − i cycles, where i is the stage holding the load. The bubble inserted each stall cycle guarantees forward progress.
- Destination register 0 never creates a match or a hazard.

Test Plan:
- Reset with rst = 1 for 5 ns mid-cycle after random traffic → all outputs 0 immediately; first instruction after release gives fad = 0, fbd = 0.
- Back-to-back ALU writes: instruction 1 writes r3, next instruction reads idRs = 3, idRt = 3 → fad = 1, fbd = 1. Instruction two later reading r3 with no younger writer → select 2.
- Youngest wins: r5 written in EX and in MEM, decode reads idRs = 5 → fad = 1, not 2. Write to r0 followed by a read of r0 → fad = 0.
- Load-use, LOAD_LAT = 1: load r7, then decode reads r7 → stall = 1 for exactly 1 cycle, EX gets a bubble, then fad = 2, stallCnt = 1. With LOAD_LAT = 2 → stall lasts 2 cycles.
- Branch flush, FLUSH_CYCLES = 2: branchTaken pulses 1 cycle → flush high for 2 cycles, two bubbles enter EX, flushCnt = 2. branchTaken during a load-use hazard → stall = 0 and flush = 1.
- Saturation with CNT_W = 4: hold a hazard for 20 cycles → stallCnt = 15 and stays 15.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle between the pipeline datapath and the forwarding/hazard unit.
// The datapath drives the decode fields; the unit returns selects, stall/flush and counters.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NSTAGES = 3,
    parameter int CNT_W   = 16
);
    localparam int FW = $clog2(NSTAGES + 1);

    logic              idValid;
    logic [REG_AW-1:0] idRs;
    logic [REG_AW-1:0] idRt;
    logic [REG_AW-1:0] idDst;
    logic              idRegWrite;
    logic              idIsLoad;
    logic              branchTaken;
    logic [FW-1:0]     fad;
    logic [FW-1:0]     fbd;
    logic              stall;
    logic              flush;
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    modport master (
        output idValid, idRs, idRt, idDst, idRegWrite, idIsLoad, branchTaken,
        input  fad, fbd, stall, flush, stallCnt, flushCnt
    );

    modport slave (
        input  idValid, idRs, idRt, idDst, idRegWrite, idIsLoad, branchTaken,
        output fad, fbd, stall, flush, stallCnt, flushCnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks in-flight destinations over NSTAGES post-decode
// stages and derives operand forward selects, load-use stalls, branch flush and event counters.
module fwd_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int NSTAGES      = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
    fwd_hazard_unit_if.slave bus
);
    localparam int FW = $clog2(NSTAGES + 1);

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [REG_AW-1:0] dst;
    } entry_t;

    entry_t           sb [NSTAGES];
    logic [1:0]       flush_down;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [FW-1:0]    sel_a;
    logic [FW-1:0]    sel_b;
    logic             hit_a;
    logic             hit_b;
    logic             haz_a;
    logic             haz_b;
    logic             stall;
    logic             flush;

    // Youngest matching stage wins; a load that is not yet forwardable blocks instead.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = 0; i < NSTAGES; i++) begin
            if (!hit_a && sb[i].v && sb[i].we && (sb[i].dst == bus.idRs) && (bus.idRs != '0)) begin
                hit_a = 1'b1;
                if (sb[i].ld && (i < LOAD_LAT)) haz_a = 1'b1;
                else                            sel_a = FW'(i + 1);
            end
            if (!hit_b && sb[i].v && sb[i].we && (sb[i].dst == bus.idRt) && (bus.idRt != '0)) begin
                hit_b = 1'b1;
                if (sb[i].ld && (i < LOAD_LAT)) haz_b = 1'b1;
                else                            sel_b = FW'(i + 1);
            end
        end
    end

    assign flush = bus.branchTaken | (flush_down != 2'd0);
    assign stall = bus.idValid & (haz_a | haz_b) & ~flush;

    assign bus.fad      = sel_a;
    assign bus.fbd      = sel_b;
    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.stallCnt = stall_cnt;
    assign bus.flushCnt = flush_cnt;

    // A stalled or squashed decode slot enters EX as an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTAGES; i++) sb[i] <= '0;
            flush_down <= 2'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            for (int i = 1; i < NSTAGES; i++) sb[i] <= sb[i-1];
            if (stall || flush) begin
                sb[0] <= '0;
            end else begin
                sb[0].v   <= bus.idValid;
                sb[0].we  <= bus.idRegWrite;
                sb[0].ld  <= bus.idIsLoad;
                sb[0].dst <= bus.idDst;
            end

            if (bus.branchTaken)      flush_down <= 2'(FLUSH_CYCLES - 1);
            else if (flush_down != 0) flush_down <= flush_down - 2'd1;

            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: two unit configurations share the decode stimulus and are compared
// against an instruction-history model, a directed vector table and saturation/reset sequences.
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid;
    logic [4:0] in_rs;
    logic [4:0] in_rt;
    logic [4:0] in_dst;
    logic       in_we;
    logic       in_ld;
    logic       in_br;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .NSTAGES(3), .CNT_W(4))  bus0 ();
    fwd_hazard_unit_if #(.REG_AW(5), .NSTAGES(4), .CNT_W(16)) bus1 ();

    assign bus0.idValid = in_valid;     assign bus1.idValid = in_valid;
    assign bus0.idRs = in_rs;           assign bus1.idRs = in_rs;
    assign bus0.idRt = in_rt;           assign bus1.idRt = in_rt;
    assign bus0.idDst = in_dst;         assign bus1.idDst = in_dst;
    assign bus0.idRegWrite = in_we;     assign bus1.idRegWrite = in_we;
    assign bus0.idIsLoad = in_ld;       assign bus1.idIsLoad = in_ld;
    assign bus0.branchTaken = in_br;    assign bus1.branchTaken = in_br;

    fwd_hazard_unit #(.REG_AW(5), .NSTAGES(3), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(4))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fwd_hazard_unit #(.REG_AW(5), .NSTAGES(4), .LOAD_LAT(2), .FLUSH_CYCLES(1), .CNT_W(16))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Model: recent instruction history per configuration, youngest first.
    typedef struct {bit v; bit we; bit ld; int dst;} instr_t;
    typedef instr_t q_t[$];
    q_t hist0;
    q_t hist1;
    int flush_left [2];
    int scnt [2];
    int fcnt [2];
    bit pst [2];
    bit pfl [2];
    int total = 0;
    int bad = 0;

    typedef struct {
        bit v; int rs; int rt; int dst; bit we; bit ld; bit br;
        int fad; int fbd; bit st; bit fl;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lookup(input q_t h, input int lat, input int s, output bit haz);
        haz = 1'b0;
        for (int i = 0; i < h.size(); i++) begin
            if (h[i].v && h[i].we && h[i].dst == s && s != 0) begin
                if (h[i].ld && i < lat) begin
                    haz = 1'b1;
                    return 0;
                end
                return i + 1;
            end
        end
        return 0;
    endfunction

    function automatic q_t push_hist(input q_t h, input instr_t e, input int depth);
        q_t r = h;
        r.push_front(e);
        if (r.size() > depth) void'(r.pop_back());
        return r;
    endfunction

    task automatic reset_model();
        hist0 = {};
        hist1 = {};
        for (int m = 0; m < 2; m++) begin
            flush_left[m] = 0; scnt[m] = 0; fcnt[m] = 0; pst[m] = 0; pfl[m] = 0;
        end
    endtask

    task automatic apply_stimulus(input bit v, input int rs, input int rt, input int dst,
                                  input bit we, input bit ld, input bit br);
        in_valid = v; in_rs = 5'(rs); in_rt = 5'(rt); in_dst = 5'(dst);
        in_we = we; in_ld = ld; in_br = br;
        @(negedge clk);
    endtask

    // Compare both configurations against the history model at mid-cycle.
    task automatic check_output();
        int fa, fb;
        bit ha, hb;
        for (int m = 0; m < 2; m++) begin
            pfl[m] = in_br || flush_left[m] > 0;
            if (m == 0) begin
                fa = lookup(hist0, 1, int'(in_rs), ha);
                fb = lookup(hist0, 1, int'(in_rt), hb);
            end else begin
                fa = lookup(hist1, 2, int'(in_rs), ha);
                fb = lookup(hist1, 2, int'(in_rt), hb);
            end
            pst[m] = in_valid && (ha || hb) && !pfl[m];
            if (m == 0) begin
                check("u0.fad", int'(bus0.fad), fa);
                check("u0.fbd", int'(bus0.fbd), fb);
                check("u0.stall", int'(bus0.stall), int'(pst[0]));
                check("u0.flush", int'(bus0.flush), int'(pfl[0]));
                check("u0.stallCnt", int'(bus0.stallCnt), scnt[0]);
                check("u0.flushCnt", int'(bus0.flushCnt), fcnt[0]);
            end else begin
                check("u1.fad", int'(bus1.fad), fa);
                check("u1.fbd", int'(bus1.fbd), fb);
                check("u1.stall", int'(bus1.stall), int'(pst[1]));
                check("u1.flush", int'(bus1.flush), int'(pfl[1]));
                check("u1.stallCnt", int'(bus1.stallCnt), scnt[1]);
                check("u1.flushCnt", int'(bus1.flushCnt), fcnt[1]);
            end
        end
    endtask

    task automatic advance();
        instr_t e;
        int fc, cmax;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (pst[m] || pfl[m]) e = '{0, 0, 0, 0};
            else                  e = '{in_valid, in_we, in_ld, int'(in_dst)};
            if (m == 0) hist0 = push_hist(hist0, e, 3);
            else        hist1 = push_hist(hist1, e, 4);
            fc   = (m == 0) ? 2 : 1;
            cmax = (m == 0) ? 15 : 65535;
            if (pst[m] && scnt[m] < cmax) scnt[m]++;
            if (pfl[m] && fcnt[m] < cmax) fcnt[m]++;
            if (in_br)                   flush_left[m] = fc - 1;
            else if (flush_left[m] > 0)  flush_left[m]--;
        end
        #1;
    endtask

    task automatic cycle(input bit v, input int rs, input int rt, input int dst,
                         input bit we, input bit ld, input bit br);
        apply_stimulus(v, rs, rt, dst, we, ld, br);
        check_output();
        advance();
    endtask

    initial begin
        // Expectations for the LOAD_LAT=1, FLUSH_CYCLES=2, 3-stage configuration.
        tbl[0]  = '{1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 3, 4, 1, 0, 0, 1, 1, 0, 0};
        tbl[2]  = '{1, 3, 0, 0, 0, 0, 0, 2, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 5, 5, 0, 1, 0, 0, 1, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 7, 1, 2, 1, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{1, 7, 1, 2, 1, 0, 0, 2, 0, 0, 0};
        tbl[10] = '{1, 2, 0, 8, 1, 0, 1, 1, 0, 0, 1};
        tbl[11] = '{1, 2, 0, 9, 1, 0, 0, 2, 0, 0, 1};
        tbl[12] = '{1, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 6, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[15] = '{1, 0, 6, 0, 0, 0, 0, 0, 2, 0, 1};
        tbl[16] = '{1, 0, 6, 0, 0, 0, 0, 0, 3, 0, 0};

        in_valid = 0; in_rs = 0; in_rt = 0; in_dst = 0; in_we = 0; in_ld = 0; in_br = 0;
        reset_model();
        @(negedge clk);
        check_output();
        check("rst.stall", int'(bus0.stall), 0);
        check("rst.flush", int'(bus0.flush), 0);
        rst = 1'b0;
        advance();

        for (int r = 0; r < 17; r++) begin
            apply_stimulus(tbl[r].v, tbl[r].rs, tbl[r].rt, tbl[r].dst,
                           tbl[r].we, tbl[r].ld, tbl[r].br);
            check($sformatf("tbl%0d.fad", r), int'(bus0.fad), tbl[r].fad);
            check($sformatf("tbl%0d.fbd", r), int'(bus0.fbd), tbl[r].fbd);
            check($sformatf("tbl%0d.stall", r), int'(bus0.stall), int'(tbl[r].st));
            check($sformatf("tbl%0d.flush", r), int'(bus0.flush), int'(tbl[r].fl));
            check_output();
            advance();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check("tbl.stallCnt", int'(bus0.stallCnt), 1);
        check("tbl.flushCnt", int'(bus0.flushCnt), 4);
        check_output();
        advance();

        rst = 1'b1;
        reset_model();
        #2;
        rst = 1'b0;
        advance();

        // Repeated load-use pairs drive the 4-bit stall counter into saturation.
        for (int k = 0; k < 20; k++) begin
            cycle(1, 0, 0, 7, 1, 1, 0);
            cycle(1, 7, 0, 3, 1, 0, 0);
            cycle(1, 7, 0, 3, 1, 0, 0);
            cycle(1, 7, 0, 3, 1, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check("sat.stallCnt", int'(bus0.stallCnt), 15);
        check("sat.flushCnt0", int'(bus0.flushCnt), 0);
        check_output();
        advance();
        for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)  cycle(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check("sat.flushCnt", int'(bus0.flushCnt), 15);
        check("sat.stallHold", int'(bus0.stallCnt), 15);
        check_output();
        advance();

        for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 8) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), ($urandom % 5) != 0, ($urandom % 10) < 3,
                  ($urandom % 12) == 0);
        end

        // Mid-cycle asynchronous reset after random traffic.
        in_valid = 0; in_rs = 3; in_rt = 3; in_dst = 0; in_we = 0; in_ld = 0; in_br = 0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.fad", int'(bus0.fad), 0);
        check("arst.fbd", int'(bus0.fbd), 0);
        check("arst.stall", int'(bus0.stall), 0);
        check("arst.flush", int'(bus0.flush), 0);
        check("arst.stallCnt", int'(bus0.stallCnt), 0);
        check("arst.flushCnt1", int'(bus1.flushCnt), 0);
        #4;
        rst = 1'b0;
        reset_model();
        advance();
        apply_stimulus(1, 3, 3, 3, 1, 0, 0);
        check("post.fad", int'(bus0.fad), 0);
        check("post.fbd", int'(bus0.fbd), 0);
        check_output();
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
